// File: rtl/ioctl_cart_loader.sv
// Receives the HPS ioctl download for the cartridge slot and writes each byte into
// cartridge RAM through a one-entry buffer with a req/ack port, stalling the host via ioctl_wait.
module ioctl_cart_loader #(
   parameter int          ADDR_W     = 12,
   parameter logic [7:0]  CART_INDEX = 8'h01,
   parameter logic [7:0]  INDEX_MASK = 8'h3F
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic              loading,
   output logic              cart_valid,
   output logic [ADDR_W:0]   cart_size,
   output logic              err_overflow,
   output logic              err_protocol,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   localparam logic [ADDR_W:0] SIZE_ONE = 1;

   // Handshake: mem_req rises the cycle after a byte is buffered and holds
   // mem_addr/mem_data stable until a cycle with mem_ack; ioctl_wait mirrors
   // the buffer-full flag so a compliant host never strobes into a full buffer.
   logic [1:0]        state_q, state_d;
   logic              dl_q, dl_d;
   logic              full_q, full_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              loading_q, loading_d;
   logic              valid_q, valid_d;
   logic [ADDR_W:0]   size_q, size_d;
   logic              ovf_q, ovf_d;
   logic              prot_q, prot_d;

   logic              rise, match, ack, in_range;
   logic [ADDR_W:0]   next_size;

   always_comb begin
      state_d   = state_q;
      dl_d      = ioctl_download;
      full_d    = full_q;
      addr_d    = addr_q;
      data_d    = data_q;
      loading_d = loading_q;
      valid_d   = valid_q;
      size_d    = size_q;
      ovf_d     = ovf_q;
      prot_d    = prot_q;

      rise      = ioctl_download & ~dl_q;
      match     = ((ioctl_index ^ CART_INDEX) & INDEX_MASK) == 8'h00;
      ack       = mem_ack & full_q;
      in_range  = (ioctl_addr >> ADDR_W) == 25'd0;
      next_size = {1'b0, addr_q} + SIZE_ONE;

      // An ack retires the buffered byte in LOAD and FLUSH alike; acks without a request are ignored.
      if (ack) begin
         full_d = 1'b0;
         if (next_size > size_q) size_d = next_size;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (rise && match) begin
               state_d   = ST_LOAD;
               loading_d = 1'b1;
               valid_d   = 1'b0;
               size_d    = '0;
               ovf_d     = 1'b0;
               prot_d    = 1'b0;
            end
         end
         ST_LOAD: begin
            if (ioctl_wr) begin
               if (!in_range) begin
                  ovf_d = 1'b1;
               end else if (!full_q || mem_ack) begin
                  addr_d = ioctl_addr[ADDR_W-1:0];
                  data_d = ioctl_dout;
                  full_d = 1'b1;
               end else begin
                  prot_d = 1'b1;
               end
            end
            if (!ioctl_download) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (!full_q) begin
               state_d   = ST_DONE;
               loading_d = 1'b0;
               valid_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // dl_q resets high so a download still asserted across reset is not seen as a new edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         dl_q      <= 1'b1;
         full_q    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         loading_q <= 1'b0;
         valid_q   <= 1'b0;
         size_q    <= '0;
         ovf_q     <= 1'b0;
         prot_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dl_q      <= dl_d;
         full_q    <= full_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         loading_q <= loading_d;
         valid_q   <= valid_d;
         size_q    <= size_d;
         ovf_q     <= ovf_d;
         prot_q    <= prot_d;
      end
   end

   assign ioctl_wait   = full_q;
   assign mem_req      = full_q;
   assign mem_addr     = addr_q;
   assign mem_data     = data_q;
   assign loading      = loading_q;
   assign cart_valid   = valid_q;
   assign cart_size    = size_q;
   assign err_overflow = ovf_q;
   assign err_protocol = prot_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_ioctl_cart_loader.sv
// Bench for ioctl_cart_loader: host driver tasks, an auto-acking RAM responder and a
// scoreboard of expected writes, size and error flags derived from the download rules.
module tb_ioctl_cart_loader;

   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              ioctl_download = 1'b0;
   logic [7:0]        ioctl_index = 8'h00;
   logic              ioctl_wr = 1'b0;
   logic [24:0]       ioctl_addr = '0;
   logic [7:0]        ioctl_dout = '0;
   logic              ioctl_wait;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_req;
   logic              mem_ack;
   logic              loading;
   logic              cart_valid;
   logic [ADDR_W:0]   cart_size;
   logic              err_overflow;
   logic              err_protocol;
   logic [1:0]        dbg_state;

   logic ack_auto = 1'b0;
   logic ack_man  = 1'b0;
   assign mem_ack = ack_auto | ack_man;

   ioctl_cart_loader #(.ADDR_W(ADDR_W), .CART_INDEX(8'h01), .INDEX_MASK(8'h3F)) dut (
      .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_req(mem_req), .mem_ack(mem_ack),
      .loading(loading), .cart_valid(cart_valid), .cart_size(cart_size),
      .err_overflow(err_overflow), .err_protocol(err_protocol), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Scoreboard / reference model state.
   logic [ADDR_W+7:0] exp_q[$];
   logic              auto_mode = 1'b0;
   int                ack_delay = 0;
   bit                in_window = 0;
   bit                exp_valid = 0;
   int                exp_size = 0;
   bit                exp_ovf = 0;
   bit                exp_prot = 0;

   // RAM responder: acks each request ack_delay cycles after it is first seen.
   initial begin
      int cnt;
      logic [ADDR_W+7:0] e;
      cnt = 0;
      forever begin
         @(negedge clk);
         ack_auto = 1'b0;
         if (auto_mode && mem_req) begin
            if (cnt >= ack_delay) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL ram_write unexpected: got addr=%h data=%h, required none", mem_addr, mem_data);
               end else begin
                  e = exp_q.pop_front();
                  if ({mem_addr, mem_data} !== e) begin
                     n_fail++;
                     $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                              mem_addr, mem_data, e[ADDR_W+7:8], e[7:0]);
                  end
               end
               ack_auto = 1'b1;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic start_download(input logic [7:0] idx);
      bit m;
      m = ((idx ^ 8'h01) & 8'h3F) == 8'h00;
      ioctl_index = idx;
      ioctl_download = 1'b1;
      @(negedge clk);
      if (m) begin
         in_window = 1; exp_valid = 0; exp_size = 0; exp_ovf = 0; exp_prot = 0;
      end else begin
         in_window = 0;
      end
      n_cmp++;
      if (loading !== m) begin
         n_fail++;
         $display("FAIL start_loading idx=%h: got %b, required %b", idx, loading, m);
      end
      n_cmp++;
      if ({cart_valid, cart_size} !== {exp_valid, 13'(exp_size)}) begin
         n_fail++;
         $display("FAIL start_size idx=%h: got valid=%b size=%h, required valid=%b size=%h",
                  idx, cart_valid, cart_size, exp_valid, exp_size);
      end
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      int t;
      bit acc;
      t = 0;
      while (ioctl_wait === 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (ioctl_wait !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_timeout: ioctl_wait got %b, required 0", ioctl_wait);
      end
      acc = in_window && (a < 25'h1000);
      if (acc) begin
         exp_q.push_back({a[ADDR_W-1:0], d});
         if (int'(a) + 1 > exp_size) exp_size = int'(a) + 1;
      end
      if (in_window && !acc) exp_ovf = 1;
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      n_cmp++;
      if (mem_req !== acc || (acc && {mem_addr, mem_data} !== {a[ADDR_W-1:0], d})) begin
         n_fail++;
         $display("FAIL req_latency a=%h: got req=%b addr=%h data=%h, required req=%b data=%h",
                  a, mem_req, mem_addr, mem_data, acc, d);
      end
      n_cmp++;
      if (err_overflow !== exp_ovf) begin
         n_fail++;
         $display("FAIL err_overflow a=%h: got %b, required %b", a, err_overflow, exp_ovf);
      end
   endtask

   task automatic end_download();
      int t;
      ioctl_download = 1'b0;
      t = 0;
      while (in_window && cart_valid !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      if (in_window) exp_valid = 1;
      in_window = 0;
      n_cmp++;
      if ({loading, cart_valid, cart_size} !== {1'b0, exp_valid, 13'(exp_size)}) begin
         n_fail++;
         $display("FAIL end_status: got loading=%b valid=%b size=%h, required loading=0 valid=%b size=%h",
                  loading, cart_valid, cart_size, exp_valid, exp_size);
      end
      n_cmp++;
      if ({err_overflow, err_protocol} !== {exp_ovf, exp_prot}) begin
         n_fail++;
         $display("FAIL end_errors: got ovf=%b prot=%b, required ovf=%b prot=%b",
                  err_overflow, err_protocol, exp_ovf, exp_prot);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL lost_writes: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic check_all_zero(input string name);
      n_cmp++;
      if ({ioctl_wait, mem_req, mem_addr, mem_data, loading, cart_valid, cart_size,
           err_overflow, err_protocol} !== '0) begin
         n_fail++;
         $display("FAIL %s: got wait=%b req=%b addr=%h data=%h load=%b valid=%b size=%h ovf=%b prot=%b, required all 0",
                  name, ioctl_wait, mem_req, mem_addr, mem_data, loading, cart_valid, cart_size,
                  err_overflow, err_protocol);
      end
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1 check_all_zero("reset_state");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_all_zero("after_reset");
   endtask

   task automatic test_basic();
      auto_mode = 1'b1; ack_delay = 0;
      start_download(8'h01);
      for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(i));
      end_download();
   endtask

   task automatic test_delay();
      int cnt;
      auto_mode = 1'b1; ack_delay = 5;
      start_download(8'h01);
      for (int i = 0; i < 4; i++) begin
         send_byte(25'($urandom_range(0, 4095)), 8'($urandom));
         cnt = 0;
         while (ioctl_wait === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
         end
         n_cmp++;
         if (cnt != 6) begin
            n_fail++;
            $display("FAIL wait_window: got %0d cycles high, required 6", cnt);
         end
      end
      end_download();
   endtask

   task automatic test_random();
      auto_mode = 1'b1;
      start_download(8'h41);
      for (int i = 0; i < 24; i++) begin
         ack_delay = $urandom_range(0, 3);
         send_byte(25'($urandom_range(0, 4095)), 8'($urandom));
      end
      end_download();
   endtask

   task automatic test_protocol();
      logic [24:0] a, b;
      logic [7:0] da, db;
      auto_mode = 1'b0; ack_delay = 0;
      a = 25'($urandom_range(0, 4095)); b = 25'($urandom_range(0, 4095));
      da = 8'($urandom); db = 8'($urandom);
      start_download(8'h01);
      ioctl_addr = a; ioctl_dout = da; ioctl_wr = 1'b1;
      @(negedge clk);
      ioctl_addr = b; ioctl_dout = db;
      @(negedge clk);
      ioctl_wr = 1'b0;
      exp_prot = 1; exp_size = int'(a) + 1;
      n_cmp++;
      if ({mem_req, ioctl_wait, err_protocol, mem_addr, mem_data} !== {3'b111, a[ADDR_W-1:0], da}) begin
         n_fail++;
         $display("FAIL protocol_drop: got req=%b wait=%b prot=%b addr=%h data=%h, required 1 1 1 addr=%h data=%h",
                  mem_req, ioctl_wait, err_protocol, mem_addr, mem_data, a[ADDR_W-1:0], da);
      end
      ack_man = 1'b1;
      @(negedge clk);
      ack_man = 1'b0;
      n_cmp++;
      if ({mem_req, ioctl_wait} !== 2'b00) begin
         n_fail++;
         $display("FAIL ack_clears: got req=%b wait=%b, required 0 0", mem_req, ioctl_wait);
      end
      end_download();
   endtask

   task automatic test_back_to_back();
      logic [24:0] a, b;
      logic [7:0] da, db;
      auto_mode = 1'b0;
      a = 25'($urandom_range(0, 4095)); b = 25'($urandom_range(0, 4095));
      da = 8'($urandom); db = 8'($urandom);
      start_download(8'h01);
      ioctl_addr = a; ioctl_dout = da; ioctl_wr = 1'b1;
      @(negedge clk);
      ioctl_addr = b; ioctl_dout = db; ack_man = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0; ack_man = 1'b0;
      n_cmp++;
      if ({mem_req, err_protocol, mem_addr, mem_data} !== {2'b10, b[ADDR_W-1:0], db}) begin
         n_fail++;
         $display("FAIL same_cycle_wr_ack: got req=%b prot=%b addr=%h data=%h, required 1 0 addr=%h data=%h",
                  mem_req, err_protocol, mem_addr, mem_data, b[ADDR_W-1:0], db);
      end
      ack_man = 1'b1;
      @(negedge clk);
      ack_man = 1'b0;
      exp_size = ((a > b) ? int'(a) : int'(b)) + 1;
      end_download();
   endtask

   task automatic test_overflow();
      auto_mode = 1'b1; ack_delay = 1;
      start_download(8'h01);
      send_byte(25'h1000, 8'hA5);
      send_byte(25'($urandom_range(32'h1001, 32'h1FF_FFFF)), 8'($urandom));
      send_byte(25'h0FFF, 8'h5A);
      end_download();
   endtask

   task automatic test_index();
      auto_mode = 1'b1; ack_delay = 0;
      start_download(8'h02);
      send_byte(25'($urandom_range(0, 4095)), 8'($urandom));
      n_cmp++;
      if ({loading, ioctl_wait} !== 2'b00) begin
         n_fail++;
         $display("FAIL ignored_index: got loading=%b wait=%b, required 0 0", loading, ioctl_wait);
      end
      end_download();
   endtask

   task automatic test_reset_mid();
      auto_mode = 1'b0;
      start_download(8'h01);
      ioctl_addr = 25'h123; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_all_zero("reset_mid");
      @(negedge clk);
      reset_n = 1'b1;
      in_window = 0; exp_valid = 0; exp_size = 0; exp_ovf = 0; exp_prot = 0;
      repeat (3) @(negedge clk);
      check_all_zero("no_restart_while_high");
      ioctl_download = 1'b0;
      @(negedge clk);
      start_download(8'h01);
      end_download();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_delay();
      test_random();
      test_protocol();
      test_back_to_back();
      test_overflow();
      test_index();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
